// File: rtl/seg7_ctrl_pkg.sv
// Shared types and constants for the six-digit seven-segment display controller.
package seg7_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam int NUM_DIGITS  = 6;
    localparam int MAX_DISPLAY = 999999;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [23:0] bcd_adjust(input logic [23:0] b);
        logic [23:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Value/decimal-point handshake between the measurement datapath and the display controller.
interface seg7_display_ctrl_if #(
    parameter int WIDTH = 20
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_value;
    logic [2:0]       in_dp;

    modport master (output in_valid, output in_value, output in_dp, input  in_ready);
    modport slave  (input  in_valid, input  in_value, input  in_dp, output in_ready);
endinterface

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD nibble to active-low seven-segment glyph (bit 0 = a ... bit 6 = g).
module seg7_bcd_decode
    import seg7_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);
    always_comb begin
        case (bcd)
            4'd0:    seg_n = 7'b1000000;
            4'd1:    seg_n = 7'b1111001;
            4'd2:    seg_n = 7'b0100100;
            4'd3:    seg_n = 7'b0110000;
            4'd4:    seg_n = 7'b0011001;
            4'd5:    seg_n = 7'b0010010;
            4'd6:    seg_n = 7'b0000010;
            4'd7:    seg_n = 7'b1111000;
            4'd8:    seg_n = 7'b0000000;
            4'd9:    seg_n = 7'b0010000;
            default: seg_n = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seg7_display_ctrl.sv
// Six-digit display controller: shift-add-3 BCD conversion, leading-zero blanking, overrange 'E'.
// Optional macro SEG7_CTRL_BLINK_EN makes the overrange 'E' blink with half-period BLINK_DIV.
//   state    | meaning
//   ST_IDLE  | ready for a value, outputs hold the last image
//   ST_CONV  | one shift-add-3 iteration per cycle, WIDTH iterations
//   ST_LATCH | register the display image, return to idle
module seg7_display_ctrl
    import seg7_ctrl_pkg::*;
#(
    parameter int WIDTH     = 20,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_display_ctrl_if.slave   in_if,
    output logic                 busy,
    output logic                 overrange,
    output logic [41:0]          hex_n,
    output logic [5:0]           dp_n
);
    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 1 || WIDTH > 20 || BLINK_DIV < 1) begin : g_bad_param
        $error("seg7_display_ctrl: WIDTH must be 1..20 and BLINK_DIV >= 1");
    end

    state_t           state;
    logic [WIDTH-1:0] bin;
    logic [23:0]      bcd;
    logic [CW-1:0]    cnt;
    logic [2:0]       dp_q;
    logic             ovr_q;
    logic [41:0]      hex_img;
    logic [5:0]       dp_img;
    logic [6:0]       seg [NUM_DIGITS];
    logic             over_in;

`ifdef SEG7_CTRL_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
`endif

    assign in_if.in_ready = (state == ST_IDLE);
    assign busy           = (state != ST_IDLE);
    assign over_in        = 32'(in_if.in_value) > 32'(MAX_DISPLAY);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_bcd_decode u_dec (.bcd(bcd[4*g +: 4]), .seg_n(seg[g]));
    end

    always_comb begin
        int  f;
        logic lead;
        f       = (dp_q <= 3'd5) ? int'(dp_q) : 0;
        lead    = 1'b1;
        hex_img = '1;
        dp_img  = (dp_q <= 3'd5) ? ~(6'd1 << dp_q) : 6'h3F;
        // Blank from the top down until the first nonzero digit or the floor digit.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (lead && bcd[4*k +: 4] == 4'd0 && k > f) begin
                hex_img[7*k +: 7] = SEG_BLANK;
            end else begin
                lead              = 1'b0;
                hex_img[7*k +: 7] = seg[k];
            end
        end
        if (ovr_q) begin
            hex_img = {{5{SEG_BLANK}}, SEG_E};
            dp_img  = 6'h3F;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bin       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            dp_q      <= 3'd7;
            ovr_q     <= 1'b0;
            hex_n     <= '1;
            dp_n      <= 6'h3F;
            overrange <= 1'b0;
`ifdef SEG7_CTRL_BLINK_EN
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_if.in_valid) begin
                        dp_q <= in_if.in_dp;
                        if (over_in) begin
                            ovr_q <= 1'b1;
                            state <= ST_LATCH;
                        end else begin
                            ovr_q <= 1'b0;
                            bin   <= in_if.in_value;
                            bcd   <= '0;
                            cnt   <= CW'(WIDTH);
                            state <= ST_CONV;
                        end
                    end
                end
                ST_CONV: begin
                    {bcd, bin} <= {bcd_adjust(bcd), bin} << 1;
                    cnt        <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= ST_LATCH;
                end
                ST_LATCH: begin
                    hex_n     <= hex_img;
                    dp_n      <= dp_img;
                    overrange <= ovr_q;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
`ifdef SEG7_CTRL_BLINK_EN
            if (state == ST_IDLE && in_if.in_valid) begin
                blink_cnt   <= BW'(BLINK_DIV - 1);
                blink_phase <= 1'b0;
            end else if (overrange && state == ST_IDLE) begin
                if (blink_cnt == '0) begin
                    blink_cnt    <= BW'(BLINK_DIV - 1);
                    blink_phase  <= ~blink_phase;
                    hex_n[6:0]   <= blink_phase ? SEG_E : SEG_BLANK;
                end else begin
                    blink_cnt <= blink_cnt - 1'b1;
                end
            end
`endif
        end
    end
endmodule
